// File: rtl/inst_pkg.sv
// inst_pkg: shared field positions, idle word and FSM state type
// for the kij-pass instruction sequencer.
package inst_pkg;

  localparam int INST_W = 34;

  localparam int B_ACC      = 33;
  localparam int B_CEN_P    = 32;
  localparam int B_WEN_P    = 31;
  localparam int B_AP_HI    = 30;
  localparam int B_AP_LO    = 20;
  localparam int B_CEN_X    = 19;
  localparam int B_WEN_X    = 18;
  localparam int B_AX_HI    = 17;
  localparam int B_AX_LO    = 7;
  localparam int B_OFIFO_RD = 6;
  localparam int B_IFIFO_WR = 5;
  localparam int B_IFIFO_RD = 4;
  localparam int B_L0_RD    = 3;
  localparam int B_L0_WR    = 2;
  localparam int B_EXEC     = 1;
  localparam int B_LOAD     = 0;

  localparam logic [INST_W-1:0] IDLE_INST = 34'h1_800C_0000;

  // Fields owned by drain_ctrl; the FSM word leaves them zero.
  localparam logic [INST_W-1:0] DRAIN_MASK = 34'h1_FFF0_0040;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WL0,
    S_LOAD,
    S_GAP,
    S_EXEC,
    S_FLUSH,
    S_DONE
  } state_t;

endpackage

// File: rtl/drain_ctrl.sv
// drain_ctrl: OFIFO-to-psum drain fields (out_cnt, spacing, A_pmem).
// Ports: i_en/i_clr control, i_ofifo_valid, i_kij -> o_all, o_word.
module drain_ctrl
  import inst_pkg::*;
#(
  parameter int len_nij = 16,
  parameter int addr_bw = 11,
  parameter int p_base  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_en,
  input  logic              i_clr,
  input  logic              i_ofifo_valid,
  input  logic [3:0]        i_kij,
  output logic              o_all,
  output logic [INST_W-1:0] o_word
);

  localparam int CW = $clog2(len_nij + 1);

  logic [CW-1:0]      r_cnt;
  logic               r_prev;
  logic               w_fire;
  logic [addr_bw-1:0] w_addr;

  // Never drain two cycles running: ofifo_valid needs a cycle
  // to reflect the row just popped.
  assign w_fire = i_en & i_ofifo_valid & ~r_prev
                & (r_cnt < CW'(len_nij));
  assign o_all  = (r_cnt == CW'(len_nij));

  // Wraps modulo 2^addr_bw by construction.
  assign w_addr = addr_bw'(p_base)
                + addr_bw'(i_kij) * addr_bw'(len_nij)
                + addr_bw'(r_cnt);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_prev <= 1'b0;
    end else if (i_clr) begin
      r_cnt  <= '0;
      r_prev <= 1'b0;
    end else begin
      r_prev <= w_fire;
      if (w_fire) r_cnt <= r_cnt + CW'(1);
    end
  end

  // Pmem enables are active-low, so this block supplies the
  // idle ones itself and the top can simply OR the words.
  always_comb begin
    o_word            = '0;
    o_word[B_CEN_P]   = ~w_fire;
    o_word[B_WEN_P]   = ~w_fire;
    if (w_fire) begin
      o_word[B_AP_HI:B_AP_LO] = w_addr;
      o_word[B_OFIFO_RD]      = 1'b1;
    end
  end

endmodule

// File: rtl/inst_sequencer.sv
// inst_sequencer: generates core inst words for one kij pass.
// Ports: clk, reset(n), start, kij, ofifo_valid -> inst, busy, done, err.
module inst_sequencer
  import inst_pkg::*;
#(
  parameter int col     = 8,
  parameter int row     = 8,
  parameter int len_nij = 16,
  parameter int addr_bw = 11,
  parameter int w_base  = 1024,
  parameter int x_base  = 0,
  parameter int p_base  = 0,
  parameter int gap     = 10,
  parameter int timeout = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        kij,
  input  logic              ofifo_valid,
  output logic [INST_W-1:0] inst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int TW = 16;

  state_t            r_state;
  state_t            w_nxt;
  logic [TW-1:0]     r_t;
  logic [3:0]        r_kij;
  logic              r_err;
  logic              w_start;
  logic              w_tmo;
  logic              w_all;
  logic              w_den;
  logic [INST_W-1:0] w_word;
  logic [INST_W-1:0] w_drain;

  assign w_start = (r_state == S_IDLE) & start;
  assign w_den   = (r_state == S_EXEC) | (r_state == S_FLUSH);
  assign err     = r_err;

  drain_ctrl #(
    .len_nij (len_nij),
    .addr_bw (addr_bw),
    .p_base  (p_base)
  ) u_drain (
    .clk           (clk),
    .reset         (reset),
    .i_en          (w_den),
    .i_clr         (w_start),
    .i_ofifo_valid (ofifo_valid),
    .i_kij         (r_kij),
    .o_all         (w_all),
    .o_word        (w_drain)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_t     <= '0;
      r_kij   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (w_nxt != r_state || r_state == S_IDLE) r_t <= '0;
      else r_t <= r_t + TW'(1);
      if (w_start) begin
        r_kij <= kij;
        r_err <= 1'b0;
      end else if (w_tmo) begin
        r_err <= 1'b1;
      end
    end
  end

  always_comb begin
    w_nxt = r_state;
    w_tmo = 1'b0;
    unique case (r_state)
      S_IDLE:  if (start) w_nxt = S_WL0;
      S_WL0:   if (r_t == TW'(col)) w_nxt = S_LOAD;
      S_LOAD:  if (r_t == TW'(col + row - 1)) w_nxt = S_GAP;
      S_GAP:   if (r_t == TW'(gap - 1)) w_nxt = S_EXEC;
      S_EXEC:  if (r_t == TW'(len_nij + col)) w_nxt = S_FLUSH;
      S_FLUSH: begin
        if (w_all) begin
          w_nxt = S_DONE;
        end else if (r_t == TW'(timeout - 1)) begin
          w_nxt = S_DONE;
          w_tmo = 1'b1;
        end
      end
      S_DONE:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_word = IDLE_INST & ~DRAIN_MASK;
    unique case (r_state)
      S_WL0: begin
        if (r_t < TW'(col)) begin
          w_word[B_CEN_X]         = 1'b0;
          w_word[B_AX_HI:B_AX_LO] = addr_bw'(w_base)
                                  + r_t[addr_bw-1:0];
        end
        if (r_t >= TW'(1)) w_word[B_L0_WR] = 1'b1;
      end
      S_LOAD: begin
        w_word[B_L0_RD] = 1'b1;
        w_word[B_LOAD]  = 1'b1;
      end
      S_EXEC: begin
        if (r_t < TW'(len_nij)) begin
          w_word[B_CEN_X]         = 1'b0;
          w_word[B_AX_HI:B_AX_LO] = addr_bw'(x_base)
                                  + r_t[addr_bw-1:0];
        end
        if (r_t >= TW'(1) && r_t <= TW'(len_nij))
          w_word[B_L0_WR] = 1'b1;
        if (r_t >= TW'(1)) begin
          w_word[B_L0_RD] = 1'b1;
          w_word[B_EXEC]  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inst <= IDLE_INST;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      inst <= w_word | w_drain;
      busy <= (r_state != S_IDLE) && (r_state != S_DONE);
      done <= (r_state == S_DONE);
    end
  end

endmodule
